// File: rtl/alisim_pkg.sv
// rtl/alisim_pkg.sv - shared base encoding, FSM state type and random-word mapping
package alisim_pkg;

    localparam int RND_W = 11;

    typedef logic [1:0] base_t;

    localparam base_t BASE_A = 2'd0;
    localparam base_t BASE_C = 2'd1;
    localparam base_t BASE_G = 2'd2;
    localparam base_t BASE_T = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Priority order matters: non-monotonic thresholds resolve to the first match.
    function automatic base_t map_base(
        input logic [RND_W-1:0] rnd,
        input logic [RND_W-1:0] thr_a,
        input logic [RND_W-1:0] thr_ac,
        input logic [RND_W-1:0] thr_acg
    );
        if (rnd < thr_a)
            return BASE_A;
        else if (rnd < thr_ac)
            return BASE_C;
        else if (rnd < thr_acg)
            return BASE_G;
        else
            return BASE_T;
    endfunction

endpackage

// File: rtl/base_sampler_if.sv
// rtl/base_sampler_if.sv - random-word input and base output stream of the sampler
interface base_sampler_if;
    import alisim_pkg::*;

    logic [RND_W-1:0] rnd_i;
    logic             rnd_take_o;
    base_t            base_o;
    logic             valid_o;
    logic             ready_i;

    modport master (
        input  rnd_i,
        input  ready_i,
        output rnd_take_o,
        output base_o,
        output valid_o
    );

    modport slave (
        output rnd_i,
        output ready_i,
        input  rnd_take_o,
        input  base_o,
        input  valid_o
    );

endinterface

// File: rtl/base_fifo.sv
// rtl/base_fifo.sv - DEPTH x 2-bit synchronous FIFO with occupancy counter
module base_fifo
    import alisim_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_push,
    input  base_t                      i_din,
    input  logic                       i_pop,
    output base_t                      o_dout,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH):0]     o_occ
);

    localparam int AW = $clog2(DEPTH);
    localparam int OW = AW + 1;

    base_t           r_mem [DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [OW-1:0]   r_occ;

    logic w_do_push;
    logic w_do_pop;

    assign o_full    = (r_occ == OW'(DEPTH));
    assign o_empty   = (r_occ == '0);
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    // Power-of-two depth lets the pointers wrap by plain overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_occ    <= '0;
            for (int i = 0; i < DEPTH; i++)
                r_mem[i] <= BASE_A;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= i_din;
                r_wr_ptr        <= r_wr_ptr + AW'(1);
            end
            if (w_do_pop)
                r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_do_push, w_do_pop})
                2'b10:   r_occ <= r_occ + OW'(1);
                2'b01:   r_occ <= r_occ - OW'(1);
                default: r_occ <= r_occ;
            endcase
        end
    end

    assign o_dout = r_mem[r_rd_ptr];
    assign o_occ  = r_occ;

endmodule

// File: rtl/base_sampler.sv
// rtl/base_sampler.sv - maps random words to nucleotides and streams a programmable-length sequence
// Optional C+G counter output gc_count_o enabled by defining BASE_SAMPLER_GC_EN.
module base_sampler
    import alisim_pkg::*;
#(
    parameter int SEQ_W = 16,
    parameter int DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start_i,
    input  logic [SEQ_W-1:0]     seq_len_i,
    input  logic [RND_W-1:0]     thr_a_i,
    input  logic [RND_W-1:0]     thr_ac_i,
    input  logic [RND_W-1:0]     thr_acg_i,
    base_sampler_if.master       bus,
    output logic                 busy_o,
`ifdef BASE_SAMPLER_GC_EN
    output logic                 done_o,
    output logic [SEQ_W-1:0]     gc_count_o
`else
    output logic                 done_o
`endif
);

    localparam int OCC_W = $clog2(DEPTH) + 1;

    state_t            r_state;
    logic [SEQ_W-1:0]  r_seq_len;
    logic [SEQ_W-1:0]  r_count;
    logic [RND_W-1:0]  r_thr_a;
    logic [RND_W-1:0]  r_thr_ac;
    logic [RND_W-1:0]  r_thr_acg;
    logic              r_busy;
    logic              r_done;

    logic              w_take;
    logic              w_pop;
    logic              w_full;
    logic              w_empty;
    logic              w_drained;
    logic [OCC_W-1:0]  w_occ;
    base_t             w_base;
    base_t             w_head;

    assign w_take    = (r_state == RUN) && !w_full;
    assign w_pop     = !w_empty && bus.ready_i;
    assign w_base    = map_base(bus.rnd_i, r_thr_a, r_thr_ac, r_thr_acg);
    // DRAIN never pushes, so the FIFO is empty next cycle if the last entry pops now.
    assign w_drained = (w_occ == '0) || ((w_occ == OCC_W'(1)) && w_pop);

    base_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_take),
        .i_din   (w_base),
        .i_pop   (w_pop),
        .o_dout  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_occ   (w_occ)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_seq_len <= '0;
            r_count   <= '0;
            r_thr_a   <= '0;
            r_thr_ac  <= '0;
            r_thr_acg <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start_i) begin
                        r_seq_len <= seq_len_i;
                        r_thr_a   <= thr_a_i;
                        r_thr_ac  <= thr_ac_i;
                        r_thr_acg <= thr_acg_i;
                        r_count   <= '0;
                        if (seq_len_i == '0) begin
                            r_state <= DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= RUN;
                            r_busy  <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (w_take) begin
                        r_count <= r_count + SEQ_W'(1);
                        if (r_count + SEQ_W'(1) == r_seq_len)
                            r_state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (w_drained) begin
                        r_state <= DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

`ifdef BASE_SAMPLER_GC_EN
    logic [SEQ_W-1:0] r_gc_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_gc_count <= '0;
        else if (r_state == IDLE && start_i)
            r_gc_count <= '0;
        else if (w_take && (w_base == BASE_C || w_base == BASE_G))
            r_gc_count <= r_gc_count + SEQ_W'(1);
    end

    assign gc_count_o = r_gc_count;
`endif

    assign bus.rnd_take_o = w_take;
    assign bus.valid_o    = !w_empty;
    assign bus.base_o     = w_head;
    assign busy_o         = r_busy;
    assign done_o         = r_done;

endmodule

// File: doc/base_sampler.md
# base_sampler

Downstream consumer of the 11-bit shift-register/LFSR random word. Maps each random word to a 2-bit nucleotide (A=0, C=1, G=2, T=3) by comparing it against cumulative frequency thresholds. Emits a sequence of programmable length through a small output FIFO with a valid/ready stream interface. Sits between the random-word register and the sequence writer of the simulation pipeline.

## Interface
- SEQ_W, 16, width of sequence-length and base counters
- DEPTH, 4, output FIFO entries (power of two, ≥2)
- clk  in  1  clock; all logic on posedge
- rst  in  1  reset, asynchronous, active-high
- start_i  in  1  start request, sampled only in IDLE
- seq_len_i  in  SEQ_W  number of bases to emit, latched on accepted start
- thr_a_i, thr_ac_i, thr_acg_i  in  11 each  cumulative thresholds, latched on accepted start
- rnd_i  in  11  random word from shift register, new value every cycle
- rnd_take_o  out  1  high in each cycle rnd_i is consumed
- base_o  out  2  FIFO head base
- valid_o  out  1  FIFO non-empty
- ready_i  in  1  downstream accept
- busy_o  out  1  high in RUN and DRAIN
- done_o  out  1  one-cycle pulse at end of sequence
- gc_count_o  out  SEQ_W  C+G bases emitted (only with macro; see Configuration)

## Operation
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE: on start_i=1, latch seq_len and thresholds, clear count. If seq_len_i=0, go to DONE; otherwise go to RUN. start_i in any other state is ignored.
- RUN: each cycle with FIFO occupancy < DEPTH (occupancy taken at cycle start), sample rnd_i, assert rnd_take_o, push the base, and increment count.
  - When count reaches seq_len, go to DRAIN. The final push happens in the transition cycle.
- Mapping, evaluated in priority order:
  - rnd < thr_a → A
  - else rnd < thr_ac → C
  - else rnd < thr_acg → G
  - else T
- Comparisons are unsigned 11-bit. Non-monotonic thresholds are legal; the result follows the priority order.
- DRAIN: no sampling. Go to DONE when the FIFO is empty.
- DONE: assert done_o for one cycle, then return to IDLE.
- Pop occurs on valid_o & ready_i. A push and a pop in the same cycle are both allowed. When full, the push is blocked even if a pop occurs that cycle.
- Pointers wrap modulo DEPTH. Occupancy is a separate counter of width clog2(DEPTH)+1.

## Timing
- Reset values: state=IDLE, FIFO empty, valid_o=0, base_o=0, rnd_take_o=0, busy_o=0, done_o=0, gc_count_o=0, count=0.
- Reset asserted mid-sequence: immediate return to reset values; FIFO contents are discarded.
- Start accepted in cycle N: first rnd_take_o in cycle N+1; that base appears on base_o with valid_o in cycle N+2.
- Sustained throughput with ready_i=1 is one base per cycle.
- rnd_take_o is combinational from state and occupancy. The base is registered into the FIFO.
- done_o fires in the cycle after the FIFO becomes empty in DRAIN.

## Configuration
- BASE_SAMPLER_GC_EN defined: gc_count_o exists. It counts pushed C/G bases, clears on accepted start, and holds its value after DONE.
- Without the macro: the gc_count_o port and its counter are absent. All other behaviour is identical.

## Structure
- Shared package `alisim_pkg` holds:
  - base encoding constants BASE_A/C/G/T
  - 2-bit base typedef
  - FSM state typedef
  - RND_W=11
- One sub-module, `base_fifo`: parameterised DEPTH × 2-bit synchronous FIFO with push/pop/full/empty/occupancy and the same clk/rst.

## Test plan
- Thresholds 512/1024/1536, seq_len=4, rnd_i = 100, 600, 1200, 2000, ready_i=1 → bases A,C,G,T, then done_o one cycle after the last pop; if GC enabled, gc_count_o=2.
- seq_len=0 start → no rnd_take_o, no valid_o, done_o in the cycle after start.
- seq_len=10, ready_i=0 → exactly DEPTH=4 pushes, then rnd_take_o stays low. Raise ready_i → the remaining 6 bases follow at one per cycle; 10 total.
- Full FIFO with ready_i=1 in the same cycle → pop occurs, push is blocked that cycle and resumes next cycle; no base lost or duplicated.
- start_i pulsed during RUN → ignored; latched length and thresholds unchanged.
- rst asserted with 3 bases buffered → valid_o=0 and state IDLE immediately. A new start then produces a clean sequence.
